arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 64, data bits per channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default ARB_RR, arbitration policy:
  - ARB_FIXED: fixed priority, channel 0 highest.
  - ARB_RR: round-robin.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  N  per-channel request.
REQ-007 in_data  in  N x WIDTH  per-channel payload.
REQ-008 in_ready  out  N  per-channel accept; one-hot or zero.
REQ-009 out_valid  out  1  registered output holds a word.
REQ-010 out_data  out  WIDTH  registered payload.
REQ-011 out_src  out  $clog2(N)  index of the channel that supplied out_data.
REQ-012 out_ready  in  1  downstream accept.

Function
REQ-013 Input transfer on channel i SHALL occur when in_valid[i] & in_ready[i] at a rising edge.
REQ-014 Output transfer SHALL occur when out_valid & out_ready at a rising edge.
REQ-015 The output stage SHALL be free when !out_valid | out_ready.
REQ-016 in_ready SHALL be combinational and equal grant[i] & free, where grant is one-hot over the valid channels, or zero if no channel is valid.
REQ-017 in_ready SHALL NOT depend on in_data.
REQ-018 Latency SHALL be one cycle: a word accepted at edge k appears on out_data/out_src with out_valid=1 after edge k.
REQ-019 Simultaneous input and output transfer in one cycle SHALL replace the output word with no bubble, giving full throughput of one word per cycle.
REQ-020 If the stage is free and no input transfers, out_valid SHALL go to 0 at the edge.
REQ-021 Backpressure: while out_valid & !out_ready, out_data/out_src SHALL hold and all in_ready SHALL be 0.
REQ-022 ARB_FIXED: grant goes to the lowest-indexed valid channel.
REQ-023 ARB_RR: grant goes to the first valid channel searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-024 ARB_RR: after an input transfer from channel k, ptr SHALL become k+1, wrapping to 0 when k = N-1.
REQ-025 ARB_RR: ptr SHALL hold when no input transfer occurs, including under backpressure.
REQ-026 A single requesting channel SHALL always be granted when the stage is free, whatever ptr is.
REQ-027 A channel dropping in_valid without a transfer SHALL not disturb ptr or out_* state.
REQ-028 Starvation bound in ARB_RR: a continuously valid channel SHALL be granted within N input transfers.

Reset
REQ-029 Asserting reset_n low SHALL asynchronously force:
  - out_valid = 0
  - out_data = 0
  - out_src = 0
  - ptr = 0
REQ-030 Because out_valid = 0, in_ready reduces to grant during reset.
REQ-031 Reset asserted mid-transfer SHALL discard the held word; no transfer completes on the edge coincident with reset.
REQ-032 Deassertion SHALL be synchronised externally; the first edge after release SHALL behave as from the reset state.

Structure
REQ-033 A shared package arb_pkg SHALL hold the arb_mode_e enum (ARB_FIXED, ARB_RR) and the function for the index width.
REQ-034 Arbitration SHALL live in one sub-module, rr_arbiter, parametrised by N and MODE.
  - Inputs: req, ptr.
  - Outputs: one-hot grant, grant index.
REQ-035 The arb_mux top SHALL contain only the output register, ptr register and data select.

Verification
REQ-036 Reset: hold reset_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_src=0; after release with out_ready=1, the first output has out_src=0.
REQ-037 RR fairness: N=4, all in_valid=1, out_ready=1, data[i]=i -> out_src sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
REQ-038 Fixed priority: MODE=ARB_FIXED, in_valid=4'b1010 constant, out_ready=1 -> out_src=1 every cycle; channel 3 is never granted.
REQ-039 Backpressure: out_valid=1 with out_data=0xAA and out_ready=0 for 5 cycles -> out_data holds 0xAA, in_ready=0 and ptr unchanged; out_ready=1 then releases the next channel in RR order.
REQ-040 Wrap and sparse requests: ptr=3, in_valid=4'b0001 -> grant channel 0 and ptr becomes 1; then in_valid=4'b1000 -> grant channel 3 and ptr wraps to 0.
REQ-041 Async reset mid-stream: drop reset_n between clock edges while out_valid=1 -> outputs clear immediately without waiting for an edge; ptr=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated multiplexer: arbitration policy and index sizing.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Channel index width; never below one bit so single-channel builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority from channel 0, or round-robin searching upward from ptr.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       IW   = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   idx;
  int   pick;
  logic any;

  // Scan from the farthest candidate back toward the nearest so the first hit in
  // search order is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    pick      = 0;
    any       = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (MODE == ARB_RR) ? ((int'(ptr) + off) % N) : off;
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
    if (any) begin
      grant[pick] = 1'b1;
      grant_idx   = IW'(pick);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated multiplexer with a single registered output stage and one-cycle latency.
module arb_mux
  import arb_pkg::*;
#(
  parameter int        WIDTH = 64,
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       IW    = idx_width(N)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N-1:0]            in_valid,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [IW-1:0]           out_src,
  input  logic                    out_ready
);

  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] ptr;
  logic          free;
  logic          take;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign free     = !out_valid || out_ready;
  assign in_ready = grant & {N{free}};
  assign take     = |in_ready;

  // Output word and round-robin pointer only move on an accepted input; a free stage
  // with nothing accepted simply empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_src   <= grant_idx;
      ptr       <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one round-robin and one fixed-priority instance on shared stimulus.
module tb_arb_mux;
  import arb_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic              out_ready;

  logic [N-1:0] rr_in_ready, fx_in_ready;
  logic         rr_out_valid, fx_out_valid;
  logic [W-1:0] rr_out_data, fx_out_data;
  logic [1:0]   rr_out_src, fx_out_src;

  int tests;
  int failed;

  arb_mux #(.WIDTH(W), .N(N), .MODE(ARB_RR)) dut_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_src   (rr_out_src),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(W), .N(N), .MODE(ARB_FIXED)) dut_fx (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fx_in_ready),
    .out_valid (fx_out_valid),
    .out_data  (fx_out_data),
    .out_src   (fx_out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = W'(i);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rr_out_valid !== 1'b0) begin
      failed++; $display("[TB] FAIL reset_valid: got %0b expected 0", rr_out_valid);
    end
    tests++;
    if (rr_out_data !== 8'h00) begin
      failed++; $display("[TB] FAIL reset_data: got %0h expected 0", rr_out_data);
    end
    tests++;
    if (rr_out_src !== 2'd0) begin
      failed++; $display("[TB] FAIL reset_src: got %0d expected 0", rr_out_src);
    end
    tests++;
    if (rr_in_ready !== 4'b0001) begin
      failed++; $display("[TB] FAIL reset_in_ready: got %b expected 0001", rr_in_ready);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = 2'(i % N);
      @(posedge clk);
      #1;
      tests++;
      if (rr_out_valid !== 1'b1) begin
        failed++; $display("[TB] FAIL rr_valid[%0d]: got %0b expected 1", i, rr_out_valid);
      end
      tests++;
      if (rr_out_src !== exp) begin
        failed++; $display("[TB] FAIL rr_src[%0d]: got %0d expected %0d", i, rr_out_src, exp);
      end
      tests++;
      if (rr_out_data !== W'(exp)) begin
        failed++; $display("[TB] FAIL rr_data[%0d]: got %0h expected %0h", i, rr_out_data, exp);
      end
      tests++;
      if (fx_out_src !== 2'd0) begin
        failed++; $display("[TB] FAIL fx_all_src[%0d]: got %0d expected 0", i, fx_out_src);
      end
    end
  endtask

  task automatic test_fixed();
    @(negedge clk);
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (fx_in_ready !== 4'b0010) begin
        failed++; $display("[TB] FAIL fx_in_ready[%0d]: got %b expected 0010", i, fx_in_ready);
      end
      @(posedge clk);
      #1;
      tests++;
      if (fx_out_valid !== 1'b1 || fx_out_src !== 2'd1 || fx_out_data !== 8'h01) begin
        failed++;
        $display("[TB] FAIL fx_out[%0d]: got valid=%0b src=%0d data=%0h expected valid=1 src=1 data=01",
                 i, fx_out_valid, fx_out_src, fx_out_data);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    do_reset();
    in_data[0] = 8'hAA;
    in_valid   = 4'b0001;
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'hAA || rr_out_src !== 2'd0 || dut_rr.ptr !== 2'd1) begin
      failed++;
      $display("[TB] FAIL bp_load: got valid=%0b data=%0h src=%0d ptr=%0d expected 1 aa 0 1",
               rr_out_valid, rr_out_data, rr_out_src, dut_rr.ptr);
    end
    @(negedge clk);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (rr_in_ready !== 4'b0000) begin
        failed++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0000", i, rr_in_ready);
      end
      @(posedge clk);
      #1;
      tests++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 8'hAA || rr_out_src !== 2'd0 || dut_rr.ptr !== 2'd1) begin
        failed++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%0b data=%0h src=%0d ptr=%0d expected 1 aa 0 1",
                 i, rr_out_valid, rr_out_data, rr_out_src, dut_rr.ptr);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (rr_in_ready !== 4'b0010) begin
      failed++; $display("[TB] FAIL bp_release_ready: got %b expected 0010", rr_in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_src !== 2'd1 || rr_out_data !== 8'h01 || dut_rr.ptr !== 2'd2) begin
      failed++;
      $display("[TB] FAIL bp_release: got src=%0d data=%0h ptr=%0d expected 1 01 2",
               rr_out_src, rr_out_data, dut_rr.ptr);
    end
    in_data[0] = 8'h00;
  endtask

  task automatic test_wrap();
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    do_reset();
    in_valid = 4'b0100;
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_src !== 2'd2 || dut_rr.ptr !== 2'd3) begin
      failed++; $display("[TB] FAIL wrap_setup: got src=%0d ptr=%0d expected 2 3", rr_out_src, dut_rr.ptr);
    end
    @(negedge clk);
    in_valid = 4'b0001;
    #1;
    tests++;
    if (rr_in_ready !== 4'b0001) begin
      failed++; $display("[TB] FAIL wrap_ready0: got %b expected 0001", rr_in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_src !== 2'd0 || rr_out_data !== 8'h00 || dut_rr.ptr !== 2'd1) begin
      failed++;
      $display("[TB] FAIL wrap_ch0: got src=%0d data=%0h ptr=%0d expected 0 00 1",
               rr_out_src, rr_out_data, dut_rr.ptr);
    end
    @(negedge clk);
    in_valid = 4'b1000;
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_src !== 2'd3 || rr_out_data !== 8'h03 || dut_rr.ptr !== 2'd0) begin
      failed++;
      $display("[TB] FAIL wrap_ch3: got src=%0d data=%0h ptr=%0d expected 3 03 0",
               rr_out_src, rr_out_data, dut_rr.ptr);
    end
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_valid !== 1'b0 || rr_out_src !== 2'd3 || dut_rr.ptr !== 2'd0) begin
      failed++;
      $display("[TB] FAIL idle_drain: got valid=%0b src=%0d ptr=%0d expected 0 3 0",
               rr_out_valid, rr_out_src, dut_rr.ptr);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd1 || dut_rr.ptr !== 2'd2) begin
      failed++;
      $display("[TB] FAIL async_pre: got valid=%0b src=%0d ptr=%0d expected 1 1 2",
               rr_out_valid, rr_out_src, dut_rr.ptr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_src !== 2'd0 || dut_rr.ptr !== 2'd0) begin
      failed++;
      $display("[TB] FAIL async_clear: got valid=%0b data=%0h src=%0d ptr=%0d expected 0 00 0 0",
               rr_out_valid, rr_out_data, rr_out_src, dut_rr.ptr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd0) begin
      failed++;
      $display("[TB] FAIL async_restart: got valid=%0b src=%0d expected 1 0", rr_out_valid, rr_out_src);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_rr_fairness();
    test_fixed();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
